// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall generator for the EX stage.
// Optional saturating stall counter enabled by FWD_HAZARD_STALL_COUNT_EN.
module fwd_hazard_unit #(
    parameter int REG_BITS  = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_BITS-1:0]  id_rs,
    input  logic [REG_BITS-1:0]  id_rt,
    input  logic                 id_uses_rt,
    input  logic                 id_reg_write,
    input  logic                 id_mem_to_reg,
    input  logic [REG_BITS-1:0]  id_write_reg,
    input  logic                 flush,
    output logic                 stall,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b
`ifdef FWD_HAZARD_STALL_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_count
`endif
);

    logic [REG_BITS-1:0] ex_rs;
    logic [REG_BITS-1:0] ex_rt;
    logic [REG_BITS-1:0] ex_dst;
    logic [REG_BITS-1:0] mem_dst;
    logic [REG_BITS-1:0] wb_dst;
    logic                ex_wr;
    logic                ex_load;
    logic                mem_wr;
    logic                wb_wr;

    logic                hit_ex_a;
    logic                hit_ex_b;
    logic                hit_mem_a;
    logic                hit_mem_b;
    logic                load_use;
    logic                bubble;
    logic [1:0]          fwd_a_nxt;
    logic [1:0]          fwd_b_nxt;

    always_comb begin
        hit_ex_a  = ex_wr && (ex_dst == id_rs);
        hit_ex_b  = ex_wr && (ex_dst == id_rt);
        hit_mem_a = mem_wr && (mem_dst == id_rs);
        hit_mem_b = mem_wr && (mem_dst == id_rt);
        load_use  = ex_load && (hit_ex_a || (id_uses_rt && hit_ex_b));
        stall     = id_valid && !flush && load_use;
        bubble    = flush || stall || !id_valid;
    end

    // The EX producer is younger than the MEM one, so it is checked first.
    always_comb begin
        fwd_a_nxt = 2'b00;
        priority case (1'b1)
            bubble:                fwd_a_nxt = 2'b00;
            hit_ex_a && !ex_load:  fwd_a_nxt = 2'b10;
            hit_mem_a:             fwd_a_nxt = 2'b01;
            default:               fwd_a_nxt = 2'b00;
        endcase
    end

    always_comb begin
        fwd_b_nxt = 2'b00;
        priority case (1'b1)
            bubble || !id_uses_rt: fwd_b_nxt = 2'b00;
            hit_ex_b && !ex_load:  fwd_b_nxt = 2'b10;
            hit_mem_b:             fwd_b_nxt = 2'b01;
            default:               fwd_b_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_dst    <= '0;
            ex_wr     <= 1'b0;
            ex_load   <= 1'b0;
            mem_dst   <= '0;
            mem_wr    <= 1'b0;
            wb_dst    <= '0;
            wb_wr     <= 1'b0;
            forward_a <= 2'b00;
            forward_b <= 2'b00;
        end else begin
            if (bubble) begin
                ex_wr   <= 1'b0;
                ex_load <= 1'b0;
            end else begin
                ex_rs   <= id_rs;
                ex_rt   <= id_rt;
                ex_dst  <= id_write_reg;
                ex_wr   <= id_reg_write && (id_write_reg != '0);
                ex_load <= id_mem_to_reg;
            end
            mem_dst   <= ex_dst;
            mem_wr    <= ex_wr;
            wb_dst    <= mem_dst;
            wb_wr     <= mem_wr;
            forward_a <= fwd_a_nxt;
            forward_b <= fwd_b_nxt;
        end
    end

`ifdef FWD_HAZARD_STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

    // Sources and WB state are kept for observability only.
    logic unused_state;
    assign unused_state = ^{ex_rs, ex_rt, wb_dst, wb_wr, (CNT_WIDTH > 0)};

endmodule
